// File: rtl/edge_event_pkg.sv
// Shared types and default sizing for the edge event counter.
package edge_event_pkg;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned WINDOW_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : edge_event_pkg

// File: rtl/edge_detect.sv
// Rising-edge detector for the y_in level stream.
// With EDGE_EVENT_SYNC_EN defined, d first passes through a two-flop
// synchronizer, which adds two cycles of latency.
// rise is combinational: d (or its synchronized copy) high while the
// previous-cycle sample was low.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_s;
  logic prev;

`ifdef EDGE_EVENT_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer ahead of edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign d_s = sync_q[1];
`else
  assign d_s = d;
`endif

  // Previous-cycle sample; cleared by reset so a level already high counts as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= d_s;
    end
  end

  assign rise = d_s & ~prev;

endmodule : edge_detect

// File: rtl/edge_event_counter.sv
// Windowed rising-edge event counter with a ready/valid snapshot output.
// Counts y_in rising edges over WINDOW-cycle windows while enabled and
// presents each completed window's count; a window that completes while a
// snapshot is still pending is dropped and flags the sticky overrun.
// Optional macro: EDGE_EVENT_SYNC_EN (two-flop input synchronizer).
module edge_event_counter
  import edge_event_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WINDOW = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_data,
  output logic             rise_pulse,
  output logic             overrun
);

  localparam int unsigned TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] count_sum;
  logic [CNT_W-1:0] data_nxt;
  logic             valid_nxt;
  logic             overrun_nxt;
  logic             rise;
  logic             xfer;
  logic             window_close;

  edge_detect u_edge_detect (
    .clk   (clk),
    .reset (reset),
    .d     (y_in),
    .rise  (rise)
  );

  // State, window timer, running count and snapshot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      count     <= count_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // Registered one-cycle pulse per detected rise, active in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise;
    end
  end

  // Next-state, window accounting and snapshot handshake.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    count_nxt    = count;
    valid_nxt    = out_valid;
    data_nxt     = out_data;
    overrun_nxt  = overrun;
    window_close = 1'b0;
    xfer         = out_valid & out_ready;
    count_sum    = (rise && (count != CNT_MAX)) ? count + CNT_W'(1) : count;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        count_nxt = '0;
        if (enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Leaving mid-window abandons the partial count.
          state_nxt = IDLE;
          timer_nxt = '0;
          count_nxt = '0;
        end else if (timer == TMR_LAST) begin
          window_close = 1'b1;
          timer_nxt    = '0;
          count_nxt    = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
          count_nxt = count_sum;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        count_nxt = '0;
      end
    endcase

    if (xfer) begin
      valid_nxt = 1'b0;
    end

    // A closing window loads only if the output slot is free or draining now.
    if (window_close) begin
      if (!out_valid || xfer) begin
        valid_nxt = 1'b1;
        data_nxt  = count_sum;
      end else begin
        overrun_nxt = 1'b1;
      end
    end

    // Flush wins over everything except the FSM state.
    if (clear) begin
      timer_nxt   = '0;
      count_nxt   = '0;
      valid_nxt   = 1'b0;
      data_nxt    = '0;
      overrun_nxt = 1'b0;
    end
  end

endmodule : edge_event_counter

// File: tb/tb_edge_event_counter.sv
// Self-checking bench for edge_event_counter (default build, no sync stage).
// A second instance with CNT_W=2 shares all inputs to observe saturation.
module tb_edge_event_counter;

  localparam int unsigned W   = 8;
  localparam int unsigned WIN = 16;

  logic         clk;
  logic         reset;
  logic         y_in;
  logic         enable;
  logic         clear;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         rise_pulse;
  logic         overrun;
  logic         s_out_valid;
  logic [1:0]   s_out_data;
  logic         s_rise_pulse;
  logic         s_overrun;

  int n_checks;
  int n_fail;

  // Reference model state
  bit m_run;
  int m_tmr;
  int m_cnt;
  bit m_prev;
  bit m_rise;
  bit m_ovr;
  int sb_q[$];

  edge_event_counter #(.CNT_W(W), .WINDOW(WIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .enable     (enable),
    .clear      (clear),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .rise_pulse (rise_pulse),
    .overrun    (overrun)
  );

  edge_event_counter #(.CNT_W(2), .WINDOW(WIN)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .enable     (enable),
    .clear      (clear),
    .out_ready  (out_ready),
    .out_valid  (s_out_valid),
    .out_data   (s_out_data),
    .rise_pulse (s_rise_pulse),
    .overrun    (s_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_tmr  = 0;
    m_cnt  = 0;
    m_prev = 1'b0;
    m_rise = 1'b0;
    m_ovr  = 1'b0;
    sb_q.delete();
  endtask

  // Advance one clock: score any transfer, step the model, then compare outputs.
  task automatic tick();
    bit r;
    int exp_v;
    if (!reset && !clear && sb_q.size() != 0 && out_ready) begin
      exp_v = sb_q.pop_front();
      chk("sb_data", int'(out_data), clampv(exp_v, 255));
      chk("sb_data_sat", int'(s_out_data), clampv(exp_v, 3));
    end
    if (reset) begin
      model_reset();
    end else begin
      r      = y_in && !m_prev;
      m_prev = y_in;
      m_rise = r;
      if (clear) begin
        m_tmr = 0;
        m_cnt = 0;
        m_ovr = 1'b0;
        sb_q.delete();
      end else if (!m_run) begin
        m_run = enable;
        m_tmr = 0;
        m_cnt = 0;
      end else if (!enable) begin
        m_run = 1'b0;
        m_tmr = 0;
        m_cnt = 0;
      end else if (m_tmr == int'(WIN) - 1) begin
        if (sb_q.size() == 0) sb_q.push_back(m_cnt + int'(r));
        else m_ovr = 1'b1;
        m_tmr = 0;
        m_cnt = 0;
      end else begin
        m_tmr++;
        m_cnt += int'(r);
      end
    end
    @(posedge clk);
    #1;
    chk("valid", int'(out_valid), int'(sb_q.size() != 0));
    chk("valid_sat", int'(s_out_valid), int'(sb_q.size() != 0));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("overrun_sat", int'(s_overrun), int'(m_ovr));
    chk("rise_pulse", int'(rise_pulse), int'(m_rise));
    chk("rise_pulse_sat", int'(s_rise_pulse), int'(m_rise));
  endtask

  // One full window: y_in follows mask bits 1..16, one bit per timer step.
  task automatic run_win(input logic [16:0] mask);
    for (int e = 1; e <= 16; e++) begin
      y_in = mask[e];
      tick();
    end
    y_in = 1'b0;
  endtask

  // Return to IDLE then re-enter RUN so the next tick starts at timer 0.
  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    logic [16:0] m;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    y_in      = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rise", int'(rise_pulse), 0);
    tick();
    tick();

    // A level already high after reset counts as a rise.
    reset = 1'b0;
    y_in  = 1'b1;
    tick();
    chk("post_rst_rise", int'(rise_pulse), 1);
    y_in = 1'b0;
    tick();

    // Toggle every 2 cycles, consumer always ready: 4 rises, one-cycle valid.
    out_ready = 1'b1;
    enable    = 1'b1;
    tick();
    run_win(17'h19998);
    chk("a_valid", int'(out_valid), 1);
    chk("a_data", int'(out_data), 4);
    chk("a_data_sat", int'(s_out_data), 3);
    enable = 1'b0;
    tick();
    chk("a_valid_drop", int'(out_valid), 0);

    // Three rises, consumer stalled: snapshot held, second close overruns.
    out_ready = 1'b0;
    enable    = 1'b1;
    tick();
    run_win(17'h00224);
    chk("b_valid", int'(out_valid), 1);
    chk("b_data", int'(out_data), 3);
    run_win(17'h00108);
    chk("b_overrun", int'(overrun), 1);
    chk("b_data_held", int'(out_data), 3);
    y_in = 1'b1;
    tick();
    y_in = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    chk("b_pending_kept", int'(out_valid), 1);
    chk("b_pending_data", int'(out_data), 3);
    enable = 1'b1;
    tick();

    // Clear mid-window with valid and overrun set; timer restarts from 0.
    for (int i = 0; i < 5; i++) tick();
    clear = 1'b1;
    tick();
    chk("c_valid", int'(out_valid), 0);
    chk("c_overrun", int'(overrun), 0);
    chk("c_data", int'(out_data), 0);
    clear = 1'b0;
    m = 17'h00088;
    for (int e = 1; e <= 16; e++) begin
      y_in = m[e];
      tick();
      if (e == 15) chk("c_no_early_close", int'(out_valid), 0);
    end
    y_in = 1'b0;
    chk("c_close", int'(out_valid), 1);
    chk("c_data2", int'(out_data), 2);

    // Ready only on the exact close cycle: swap snapshot, no overrun.
    m = 17'h0122A;
    for (int e = 1; e <= 16; e++) begin
      y_in      = m[e];
      out_ready = (e == 16);
      tick();
    end
    y_in = 1'b0;
    chk("d_valid", int'(out_valid), 1);
    chk("d_data", int'(out_data), 5);
    chk("d_overrun", int'(overrun), 0);
    out_ready = 1'b1;
    restart();

    // Six rises (last on the closing cycle): 8-bit sees 6, 2-bit saturates at 3.
    run_win(17'h10554);
    chk("e_valid", int'(out_valid), 1);
    chk("e_data", int'(out_data), 6);
    chk("e_data_sat", int'(s_out_data), 3);
    enable = 1'b0;
    tick();
    out_ready = 1'b0;
    enable    = 1'b1;
    tick();

    // Async reset mid-RUN with count 5, valid and overrun set.
    run_win(17'h00004);
    run_win(17'h00004);
    chk("f_overrun_pre", int'(overrun), 1);
    m = 17'h00AA8;
    for (int e = 1; e <= 11; e++) begin
      y_in = m[e];
      tick();
    end
    chk("f_rise_pre", int'(rise_pulse), 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("f_rst_valid", int'(out_valid), 0);
    chk("f_rst_data", int'(out_data), 0);
    chk("f_rst_overrun", int'(overrun), 0);
    chk("f_rst_rise", int'(rise_pulse), 0);
    y_in   = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    run_win(17'h0002A);
    chk("f_valid", int'(out_valid), 1);
    chk("f_data", int'(out_data), 3);
    enable = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_edge_event_counter
